// File: rtl/bitstream_pkg.sv
// Shared types and constants for the MP3 bitstream reader and its arbiter.
package bitstream_pkg;

  localparam int MAX_BITS = 32;
  localparam int LEN_W    = 6;

  localparam logic CL_HDR  = 1'b0;
  localparam logic CL_MAIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

endpackage

// File: rtl/bitstream_reader_arb.sv
// Two-client round-robin arbiter; the client granted last loses a tie.
module rr_arbiter2
  import bitstream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_id;

  always_comb begin
    grant_valid = |req;
    grant_id    = CL_HDR;
    if (req == 2'b11) begin
      grant_id = ~last_id;
    end else if (req[1]) begin
      grant_id = CL_MAIN;
    end
  end

  // Starting with the main-data client as "last" lets the header parser win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= CL_MAIN;
    end else if (accept) begin
      last_id <= grant_id;
    end
  end

endmodule

// File: rtl/bitstream_reader.sv
// Arbitrates two bit-field clients onto a 1-bit serial source and assembles
// the returned bits MSB-first, keeping a running count of captured bits.
module bitstream_reader
  import bitstream_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int POS_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                src_rea,
  input  logic                src_data,
  input  logic                src_empty,
  input  logic [1:0]          req,
  input  logic [LEN_W-1:0]    req_len0,
  input  logic [LEN_W-1:0]    req_len1,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                busy,
  input  logic                pos_clr,
  output logic [POS_W-1:0]    bit_pos
);

  state_t               state;
  logic                 cur_id;
  logic [LEN_W-1:0]     cur_len;
  logic [LEN_W-1:0]     iss_cnt;
  logic [LEN_W-1:0]     cap_cnt;
  logic [MAX_BITS-1:0]  data;
  logic                 rea_q;
  logic [1:0]           eligible;
  logic                 grant_valid;
  logic                 grant_id;
  logic                 start;
  logic [LEN_W-1:0]     len_raw;
  logic [LEN_W-1:0]     len_clamped;

  assign src_rea = (state == ISSUE) && !src_empty;

  // The client being answered in RESP still holds its request, so it is
  // excluded there to avoid serving it twice.
  always_comb begin
    eligible = req;
    if (state == RESP) begin
      eligible = req & ((cur_id == CL_MAIN) ? 2'b01 : 2'b10);
    end
  end

  assign start       = grant_valid && ((state == IDLE) || (state == RESP));
  assign len_raw     = (grant_id == CL_MAIN) ? req_len1 : req_len0;
  assign len_clamped = (len_raw > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len_raw;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (eligible),
    .accept      (start),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_id    <= CL_HDR;
      cur_len   <= '0;
      iss_cnt   <= '0;
      cap_cnt   <= '0;
      data      <= '0;
      rea_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      bit_pos   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rea_q     <= src_rea;

      // The source answers a strobe one cycle later, so capture follows rea_q.
      if (rea_q) begin
        data    <= {data[MAX_BITS-2:0], src_data};
        cap_cnt <= cap_cnt + LEN_W'(1);
      end
      if (pos_clr) begin
        bit_pos <= '0;
      end else if (rea_q) begin
        bit_pos <= bit_pos + POS_W'(1);
      end

      case (state)
        IDLE: begin
        end
        ISSUE: begin
          if (src_rea) begin
            iss_cnt <= iss_cnt + LEN_W'(1);
            if (iss_cnt + LEN_W'(1) == cur_len) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rea_q && (cap_cnt + LEN_W'(1) == cur_len)) begin
            state <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_data  <= data;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state   <= (len_clamped == '0) ? RESP : ISSUE;
        cur_id  <= grant_id;
        cur_len <= len_clamped;
        iss_cnt <= '0;
        cap_cnt <= '0;
        data    <= '0;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_reader.sv
// Self-checking bench for bitstream_reader: a queue-based bit source and a
// transfer-level reference model for data, latency, arbitration and bit_pos.
module tb_bitstream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_rea;
  logic        src_data = 1'b0;
  logic        src_empty;
  logic [1:0]  req;
  logic [5:0]  req_len0;
  logic [5:0]  req_len1;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        busy;
  logic        pos_clr;
  logic [15:0] bit_pos;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes  = 0;
  int empty_violations = 0;
  int model_pos  = 0;
  int last_grant = 1;
  bit src_q[$];

  bitstream_reader #(.MAX_BITS(32), .POS_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_rea   (src_rea),
    .src_data  (src_data),
    .src_empty (src_empty),
    .req       (req),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .pos_clr   (pos_clr),
    .bit_pos   (bit_pos)
  );

  always #5 clk = ~clk;

  // Serial source: each strobe pops the next bit, presented in the following cycle.
  always @(posedge clk) begin
    if (src_rea) begin
      if (src_empty) empty_violations++;
      strobes++;
      if (src_q.size() > 0) src_data <= src_q.pop_front();
      else src_data <= 1'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int clampLen(input int len);
    return (len > 32) ? 32 : len;
  endfunction

  function automatic logic [31:0] fieldOf(input logic [31:0] pat, input int n);
    if (n == 0) return 32'd0;
    if (n >= 32) return pat;
    return pat & ((32'd1 << n) - 32'd1);
  endfunction

  task automatic pushBits(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(pat[n-1-i]);
  endtask

  // One single-client transfer with an optional src_empty window and pos_clr pulse.
  task automatic applyStimulus(input int id, input int len, input logic [31:0] pattern,
                               input int stall_start, input int stall_len,
                               input int clr_idx, input bit push);
    int n, lat_exp, lat_obs, s0, got, idx;
    logic [31:0] exp_data;
    n = clampLen(len);
    exp_data = fieldOf(pattern, n);
    if (push) pushBits(pattern, n);
    if (n == 0) lat_exp = 1;
    else begin
      got = 0;
      idx = 0;
      while (got < n) begin
        idx++;
        if (!(idx >= stall_start && idx < stall_start + stall_len)) got++;
      end
      lat_exp = idx + 2;
    end
    s0 = strobes;
    lat_obs = -1;
    @(negedge clk);
    if (id == 0) req_len0 = 6'(len);
    else req_len1 = 6'(len);
    req[id] = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      src_empty = (k >= stall_start) && (k < stall_start + stall_len);
      pos_clr   = (k == clr_idx);
      if (k == 1) checkOutput("busy_during", busy, 1);
      if (rsp_valid) begin
        lat_obs = k - 1;
        break;
      end
    end
    req = 2'b00;
    src_empty = 1'b0;
    pos_clr = 1'b0;
    if (clr_idx >= 2 && clr_idx <= n + 1) model_pos = n + 1 - clr_idx;
    else model_pos = (model_pos + n) % 65536;
    last_grant = id;
    checkOutput("latency", lat_obs, lat_exp);
    checkOutput("rsp_id", rsp_id, id);
    checkOutput("rsp_data", rsp_data, exp_data);
    checkOutput("strobe_count", strobes - s0, n);
    checkOutput("bit_pos", bit_pos, model_pos);
    checkOutput("busy_at_rsp", busy, 0);
    @(negedge clk);
    checkOutput("rsp_pulse_width", rsp_valid, 0);
  endtask

  // Both clients request together; the round-robin rule decides the order.
  task automatic applyBoth(input int len0, input int len1, input logic [31:0] pat0,
                           input logic [31:0] pat1);
    int first, second, nf, ns, seen;
    logic [31:0] expf, exps;
    first  = (last_grant == 0) ? 1 : 0;
    second = 1 - first;
    nf   = clampLen(first == 0 ? len0 : len1);
    ns   = clampLen(second == 0 ? len0 : len1);
    expf = fieldOf(first == 0 ? pat0 : pat1, nf);
    exps = fieldOf(second == 0 ? pat0 : pat1, ns);
    pushBits(first == 0 ? pat0 : pat1, nf);
    pushBits(second == 0 ? pat0 : pat1, ns);
    seen = 0;
    @(negedge clk);
    req_len0 = 6'(len0);
    req_len1 = 6'(len1);
    req = 2'b11;
    for (int k = 1; k <= 400 && seen < 2; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (seen == 0) begin
          checkOutput("both_first_id", rsp_id, first);
          checkOutput("both_first_data", rsp_data, expf);
        end else begin
          checkOutput("both_second_id", rsp_id, second);
          checkOutput("both_second_data", rsp_data, exps);
        end
        req[rsp_id] = 1'b0;
        seen++;
      end
    end
    req = 2'b00;
    checkOutput("both_rsp_count", seen, 2);
    model_pos  = (model_pos + nf + ns) % 65536;
    last_grant = second;
    checkOutput("both_bit_pos", bit_pos, model_pos);
    @(negedge clk);
  endtask

  initial begin
    int found, s0, rsp_cnt;
    logic [15:0] pat16;
    rst = 1'b1;
    req = 2'b00;
    req_len0 = '0;
    req_len1 = '0;
    src_empty = 1'b0;
    pos_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_bit_pos", bit_pos, 0);
    checkOutput("reset_src_rea", src_rea, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    rst = 1'b0;
    model_pos = 0;
    last_grant = 1;
    @(negedge clk);

    applyBoth(4, 4, 32'hA, 32'h5);
    applyBoth(4, 4, 32'hA, 32'h5);
    applyStimulus(0, 12, 32'h0000_0FFF, 0, 0, 0, 1);
    applyStimulus(0, 8, 32'h0000_00C3, 3, 3, 0, 1);
    applyStimulus(1, 32, 32'hFFFF_FFFF, 0, 0, 0, 1);
    applyStimulus(0, 0, 32'hDEAD_BEEF, 0, 0, 0, 1);
    applyStimulus(1, 40, $urandom, 0, 0, 0, 1);
    applyStimulus(0, 8, 32'h0000_005A, 0, 0, 5, 1);
    applyStimulus(1, 8, 32'h0000_00A5, 0, 0, 9, 1);

    // Reset asserted during the fifth strobe of a 16-bit read.
    pat16 = 16'hB6D9;
    pushBits({16'd0, pat16}, 16);
    s0 = strobes;
    found = 0;
    @(negedge clk);
    req_len0 = 6'd16;
    req = 2'b01;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (src_rea && (strobes - s0 == 4)) begin
        found = 1;
        break;
      end
    end
    checkOutput("rst_reached_5th_strobe", found, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_src_rea", src_rea, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_rsp_id", rsp_id, 0);
    checkOutput("midrst_rsp_data", rsp_data, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_bit_pos", bit_pos, 0);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    model_pos = 0;
    last_grant = 1;
    applyStimulus(0, 4, {28'd0, pat16[11:8]}, 0, 0, 0, 0);
    src_q.delete();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom,
                    int'($urandom_range(1, 10)), int'($urandom_range(0, 4)), 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      applyBoth(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), $urandom, $urandom);
    end

    // Stream 65535 bits from a cleared counter, then one more bit to wrap it.
    @(negedge clk);
    pos_clr = 1'b1;
    @(negedge clk);
    pos_clr = 1'b0;
    model_pos = 0;
    checkOutput("pos_clr_idle", bit_pos, 0);
    rsp_cnt = 0;
    req_len0 = 6'd32;
    req = 2'b01;
    for (int k = 1; k <= 2048 * 40 && rsp_cnt < 2048; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cnt == 2047) req_len0 = 6'd31;
        if (rsp_cnt == 2048) req = 2'b00;
      end
    end
    req = 2'b00;
    model_pos = (2047 * 32 + 31) % 65536;
    last_grant = 0;
    checkOutput("stream_rsp_count", rsp_cnt, 2048);
    checkOutput("stream_bit_pos", bit_pos, model_pos);
    @(negedge clk);
    applyStimulus(1, 1, $urandom, 0, 0, 0, 1);

    checkOutput("src_empty_violations", empty_violations, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
